// File: rtl/jesd204b_rx_capture_if.sv
// Bus between the JESD204B RX link layer / software and the capture buffer.
// Ports: sample stream (adc_data0/1, data_ready), capture control (arm, abort,
// pre_len, ext_trig, thr_en, thr), read port (rd_en, rd_addr, rd_data,
// rd_valid) and status (busy, done, link_lost, trig_ts).
interface jesd204b_rx_capture_if #(
  parameter int DEPTH_LOG2 = 10,
  parameter int TS_W       = 32
);
  logic [15:0]           adc_data0;
  logic [15:0]           adc_data1;
  logic                  data_ready;
  logic                  arm;
  logic                  abort;
  logic [DEPTH_LOG2-1:0] pre_len;
  logic                  ext_trig;
  logic                  thr_en;
  logic [15:0]           thr;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [31:0]           rd_data;
  logic                  rd_valid;
  logic                  busy;
  logic                  done;
  logic                  link_lost;
  logic [TS_W-1:0]       trig_ts;

  modport master (
    output adc_data0, adc_data1, data_ready, arm, abort, pre_len,
    output ext_trig, thr_en, thr, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, done, link_lost, trig_ts
  );

  modport slave (
    input  adc_data0, adc_data1, data_ready, arm, abort, pre_len,
    input  ext_trig, thr_en, thr, rd_en, rd_addr,
    output rd_data, rd_valid, busy, done, link_lost, trig_ts
  );
endinterface

// File: rtl/jesd204b_rx_capture.sv
// Trigger-centred snapshot buffer for JESD204B RX sample pairs.
// Ports: clk, reset (sync, active-high), bus (slave side of capture bus).
module jesd204b_rx_capture #(
  parameter int DEPTH_LOG2 = 10,
  parameter int TS_W       = 32
) (
  input logic                  clk,
  input logic                  reset,
  jesd204b_rx_capture_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] addr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT,
    S_POST,
    S_DONE
  } state_e;

  localparam addr_t ONE = addr_t'(1);

  state_e          state_q, state_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  addr_t           wr_ptr_q;
  addr_t           start_addr_q;
  addr_t           p_q;
  addr_t           cnt_q;
  addr_t           rd_ptr;
  logic [TS_W-1:0] trig_ts_q;
  logic            link_lost_q;
  logic            dr_q;
  logic [31:0]     rd_data_q;
  logic            rd_valid_q;
  logic [31:0]     mem [DEPTH];

  logic [16:0]     mag;
  logic            hit;
  logic            wr_en;
  logic            idle_like;
  logic            arm_ok;
  logic            fill_last;
  logic            post_last;

  // 17-bit magnitude so that -32768 maps to +32768
  assign mag = bus.adc_data0[15]
             ? 17'd0 - {1'b1, bus.adc_data0}
             : {1'b0, bus.adc_data0};

  assign hit = bus.ext_trig
             | (bus.thr_en & (mag > {1'b0, bus.thr}));

  assign wr_en     = busy_q & bus.data_ready;
  assign idle_like = (state_q == S_IDLE) | (state_q == S_DONE);
  assign arm_ok    = bus.arm & ~bus.abort & idle_like;
  assign fill_last = cnt_q == addr_t'(p_q - ONE);
  assign post_last = cnt_q == ONE;
  assign rd_ptr    = start_addr_q + bus.rd_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // remaining = DEPTH-1-P is zero exactly when P is all ones
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.arm)
            state_d = (bus.pre_len == '0) ? S_WAIT : S_FILL;
        end
        S_FILL: begin
          if (wr_en && fill_last)
            state_d = S_WAIT;
        end
        S_WAIT: begin
          if (wr_en && hit)
            state_d = (p_q == '1) ? S_DONE : S_POST;
        end
        S_POST: begin
          if (wr_en && post_last)
            state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      S_FILL, S_WAIT, S_POST: busy_d = 1'b1;
      S_DONE:                 done_d = 1'b1;
      default:                ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      start_addr_q <= '0;
      p_q          <= '0;
      cnt_q        <= '0;
      trig_ts_q    <= '0;
      link_lost_q  <= 1'b0;
      dr_q         <= 1'b0;
    end else begin
      dr_q <= bus.data_ready;
      if (busy_q && dr_q && !bus.data_ready)
        link_lost_q <= 1'b1;
      if (arm_ok) begin
        p_q         <= bus.pre_len;
        wr_ptr_q    <= '0;
        cnt_q       <= '0;
        trig_ts_q   <= '0;
        link_lost_q <= 1'b0;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + ONE;
        unique case (state_q)
          S_FILL: cnt_q <= cnt_q + ONE;
          S_WAIT: begin
            if (hit) begin
              start_addr_q <= wr_ptr_q - p_q;
              cnt_q        <= ~p_q;
            end else if (trig_ts_q != '1) begin
              trig_ts_q <= trig_ts_q + TS_W'(1);
            end
          end
          S_POST: cnt_q <= cnt_q - ONE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_q] <= {bus.adc_data0, bus.adc_data1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en)
        rd_data_q <= mem[rd_ptr];
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.link_lost = link_lost_q;
  assign bus.trig_ts   = trig_ts_q;
endmodule

// File: tb/tb_jesd204b_rx_capture.sv
// Self-checking bench for jesd204b_rx_capture at DEPTH_LOG2 = 4.
// A queue of written samples since arm models the trigger-relative layout.
module tb_jesd204b_rx_capture;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int TS_W  = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  jesd204b_rx_capture_if #(.DEPTH_LOG2(AW), .TS_W(TS_W)) bus ();

  jesd204b_rx_capture #(.DEPTH_LOG2(AW), .TS_W(TS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_buf [DEPTH];

  task automatic idle_inputs();
    bus.adc_data0  = '0;
    bus.adc_data1  = '0;
    bus.data_ready = 1'b0;
    bus.arm        = 1'b0;
    bus.abort      = 1'b0;
    bus.pre_len    = '0;
    bus.ext_trig   = 1'b0;
    bus.thr_en     = 1'b0;
    bus.thr        = '0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
  endtask

  // kind: 0 counter {k,~k}; 1 |d0|<=1000 with spike at write 7; 2 random
  // ext_idx: >=0 write index, -1 never, -2 always, -3 random
  // dr_mode: 0 always, 1 toggle after trigger, 2 random
  task automatic capture(input string tag, input int p, input int kind,
                         input int ext_idx, input logic [15:0] spike,
                         input int dr_mode, input int rearm_at,
                         input int abort_post, input int max_writes);
    logic [31:0] hist [$];
    int          n, ti, cyc, a, r;
    bit          lost, prev_dr, dr, ext, thr_on;
    logic [15:0] d0, d1, thr_v;
    n = 0; ti = -1; cyc = 0; lost = 1'b0; prev_dr = 1'b1;
    thr_on = (kind != 0);
    thr_v  = (kind == 1) ? 16'd1000 : 16'($urandom_range(30000, 32767));
    @(negedge clk);
    bus.arm = 1'b1; bus.abort = 1'b0; bus.pre_len = AW'(p);
    bus.data_ready = 1'b1; bus.ext_trig = 1'b0;
    bus.thr_en = thr_on; bus.thr = thr_v;
    while (!(ti >= 0 && n == ti + DEPTH - p) && n < max_writes) begin
      @(negedge clk);
      bus.arm = 1'b0; bus.abort = 1'b0;
      if (cyc == 0) begin
        n_total++;
        if (bus.link_lost !== 1'b0)
          $display("FAIL %s arm_clear_lost got=%0b exp=0", tag, bus.link_lost);
        else n_pass++;
        n_total++;
        if (bus.trig_ts !== '0)
          $display("FAIL %s arm_clear_ts got=%0d exp=0", tag, bus.trig_ts);
        else n_pass++;
      end
      n_total++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0)
        $display("FAIL %s busy_run got=%0b/%0b exp=1/0 n=%0d",
                 tag, bus.busy, bus.done, n);
      else n_pass++;
      if (ti >= 0 && abort_post >= 0 && n - ti - 1 == abort_post) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.data_ready = 1'b0;
        n_total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
          $display("FAIL %s abort_idle got=%0b/%0b exp=0/0",
                   tag, bus.busy, bus.done);
        else n_pass++;
        return;
      end
      if (cyc == rearm_at) begin
        bus.arm = 1'b1;
        bus.pre_len = AW'(p + 5);
      end
      case (dr_mode)
        0:       dr = 1'b1;
        1:       dr = (ti >= 0) ? !prev_dr : 1'b1;
        default: dr = ($urandom_range(0, 3) != 0);
      endcase
      if (dr) begin
        case (kind)
          0: begin d0 = 16'(n); d1 = ~16'(n); end
          1: begin
            r  = int'($urandom_range(0, 2000)) - 1000;
            d0 = (n == 7) ? spike : 16'(r);
            d1 = 16'($urandom);
          end
          default: begin
            d0 = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
            d1 = 16'($urandom);
          end
        endcase
        if (ext_idx >= 0)       ext = (n == ext_idx);
        else if (ext_idx == -1) ext = 1'b0;
        else if (ext_idx == -2) ext = 1'b1;
        else                    ext = ($urandom_range(0, 19) == 0);
        a = int'($signed(d0));
        if (a < 0) a = -a;
        hist.push_back({d0, d1});
        if (ti < 0 && n >= p && (ext || (thr_on && a > int'(thr_v))))
          ti = n;
        n++;
      end else begin
        d0 = 16'($urandom); d1 = 16'($urandom); ext = 1'($urandom);
      end
      if (prev_dr && !dr) lost = 1'b1;
      prev_dr = dr;
      bus.data_ready = dr; bus.adc_data0 = d0;
      bus.adc_data1 = d1; bus.ext_trig = ext;
      cyc++;
    end
    @(negedge clk);
    bus.arm = 1'b0;
    if (ti < 0) begin
      n_total++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.trig_ts !== 32'(n - p))
        $display("FAIL %s no_trig got=%0b/%0b/%0d exp=1/0/%0d",
                 tag, bus.busy, bus.done, bus.trig_ts, n - p);
      else n_pass++;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      bus.data_ready = 1'b0;
      n_total++;
      if (bus.busy !== 1'b0)
        $display("FAIL %s no_trig_abort got=%0b exp=0", tag, bus.busy);
      else n_pass++;
      return;
    end
    bus.data_ready = 1'b0; bus.ext_trig = 1'b0;
    n_total++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL %s done got=%0b/%0b exp=1/0", tag, bus.done, bus.busy);
    else n_pass++;
    n_total++;
    if (bus.trig_ts !== 32'(ti - p))
      $display("FAIL %s trig_ts got=%0d exp=%0d", tag, bus.trig_ts, ti - p);
    else n_pass++;
    n_total++;
    if (bus.link_lost !== lost)
      $display("FAIL %s link_lost got=%0b exp=%0b", tag, bus.link_lost, lost);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) exp_buf[i] = hist[ti - p + i];
  endtask

  task automatic read_back(input string tag);
    for (int i = 0; i <= DEPTH; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_total++;
        if (bus.rd_valid !== 1'b0)
          $display("FAIL %s rd_valid_pre got=%0b exp=0", tag, bus.rd_valid);
        else n_pass++;
      end else begin
        n_total++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_buf[i-1])
          $display("FAIL %s rd[%0d] got=%0b/%h exp=1/%h",
                   tag, i - 1, bus.rd_valid, bus.rd_data, exp_buf[i-1]);
        else n_pass++;
      end
      if (i < DEPTH) begin
        bus.rd_en = 1'b1; bus.rd_addr = AW'(i);
      end else begin
        bus.rd_en = 1'b0; bus.rd_addr = AW'($urandom);
      end
    end
    @(negedge clk);
    n_total++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== exp_buf[DEPTH-1])
      $display("FAIL %s rd_hold got=%0b/%h exp=0/%h",
               tag, bus.rd_valid, bus.rd_data, exp_buf[DEPTH-1]);
    else n_pass++;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.link_lost !== 1'b0 ||
        bus.trig_ts !== '0 || bus.rd_valid !== 1'b0 || bus.rd_data !== '0)
      $display("FAIL %s outs got=%0b%0b%0b ts=%0d rv=%0b rd=%h exp=000 0 0 0",
               tag, bus.busy, bus.done, bus.link_lost, bus.trig_ts,
               bus.rd_valid, bus.rd_data);
    else n_pass++;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
  endtask

  task automatic test_arm_abort_same();
    @(negedge clk);
    bus.arm = 1'b1; bus.abort = 1'b1; bus.pre_len = AW'(3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.arm = 1'b0; bus.abort = 1'b0;
      n_total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0)
        $display("FAIL arm_abort busy/done got=%0b/%0b exp=0/0",
                 bus.busy, bus.done);
      else n_pass++;
    end
  endtask

  task automatic test_ext_trig();
    capture("ext", 4, 0, 20, 16'd0, 0, -1, -1, 200);
    read_back("ext");
  endtask

  task automatic test_threshold();
    capture("thr_hit", 0, 1, -1, 16'hFC17, 0, -1, -1, 200);
    read_back("thr_hit");
    capture("thr_miss", 0, 1, -1, 16'hFC18, 0, -1, -1, 40);
  endtask

  task automatic test_full_pre();
    capture("pre15", 15, 0, -2, 16'd0, 0, -1, -1, 200);
    read_back("pre15");
  endtask

  task automatic test_dr_toggle();
    capture("toggle", 3, 0, 8, 16'd0, 1, -1, -1, 200);
    read_back("toggle");
  endtask

  task automatic test_abort_post();
    capture("abort", 2, 0, 5, 16'd0, 0, -1, 4, 200);
  endtask

  task automatic test_arm_busy();
    capture("rearm", 3, 0, 9, 16'd0, 0, 2, -1, 200);
    read_back("rearm");
    capture("rearm_wait", 1, 0, 7, 16'd0, 0, 4, -1, 200);
    read_back("rearm_wait");
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      capture("rand", int'($urandom_range(0, 15)), 2, -3, 16'd0, 2,
              -1, -1, 300);
      read_back("rand");
    end
  endtask

  task automatic test_back_to_back();
    capture("b2b", 6, 2, -3, 16'd0, 0, -1, -1, 300);
    read_back("b2b");
  endtask

  task automatic test_reset_wait();
    bit pat [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    bus.arm = 1'b1; bus.pre_len = AW'(2); bus.data_ready = 1'b1;
    bus.ext_trig = 1'b0; bus.thr_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.arm = 1'b0;
      bus.data_ready = pat[i];
      bus.adc_data0 = 16'($urandom); bus.adc_data1 = 16'($urandom);
    end
    @(negedge clk);
    bus.data_ready = 1'b1;
    bus.rd_en = 1'b1; bus.rd_addr = AW'(1);
    n_total++;
    if (bus.busy !== 1'b1 || bus.link_lost !== 1'b1 || bus.trig_ts !== 32'd3)
      $display("FAIL rst_wait pre got=%0b/%0b/%0d exp=1/1/3",
               bus.busy, bus.link_lost, bus.trig_ts);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("rst_wait");
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arm_abort_same();
    test_ext_trig();
    test_threshold();
    test_full_pre();
    test_dr_toggle();
    test_abort_post();
    test_arm_busy();
    test_random();
    test_back_to_back();
    test_reset_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
